// File: rtl/ramp_gen.sv
// Triangle sweep generator. It produces the scan ramp for the actuator while
// the loop is open, pulses ramp_trigger once per sweep period, and freezes
// whenever ramp_enable is low.
module ramp_gen #(
  parameter int unsigned W_OUT = 14,
  parameter int unsigned W_PER = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ramp_enable,
  input  logic                    ramp_reset,
  input  logic signed [W_OUT-1:0] ramp_low,
  input  logic signed [W_OUT-1:0] ramp_high,
  input  logic        [W_OUT-2:0] step_size,
  input  logic        [W_PER-1:0] step_period,
  output logic signed [W_OUT-1:0] ramp_out,
  output logic                    ramp_dir,
  output logic                    ramp_trigger
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} state_t;

  state_t                  r_state;
  logic        [W_PER-1:0] r_presc;
  logic signed [W_OUT-1:0] r_out;
  logic                    r_trig;

  logic                    w_tick;
  logic                    w_degen;
  logic signed [W_OUT:0]   w_step;
  logic signed [W_OUT:0]   w_cur;
  logic signed [W_OUT:0]   w_low;
  logic signed [W_OUT:0]   w_high;
  logic signed [W_OUT:0]   w_up;
  logic signed [W_OUT:0]   w_dn;

  // Tick decode and one-bit-wider sweep arithmetic so that the next value
  // can never wrap past the signed range.
  always_comb begin
    w_tick  = (r_presc == step_period);
    w_degen = (ramp_low >= ramp_high);
    w_step  = (step_size == '0) ? (W_OUT+1)'(1) : {2'b00, step_size};
    w_cur   = {r_out[W_OUT-1], r_out};
    w_low   = {ramp_low[W_OUT-1], ramp_low};
    w_high  = {ramp_high[W_OUT-1], ramp_high};
    w_up    = w_cur + w_step;
    w_dn    = w_cur - w_step;
  end

  // Sweep state machine: prescaler, direction, ramp value and trigger pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= UP;
      r_presc <= '0;
      r_out   <= '0;
      r_trig  <= 1'b0;
    end else if (ramp_reset) begin
      r_state <= UP;
      r_presc <= '0;
      r_out   <= ramp_low;
      r_trig  <= 1'b0;
    end else if (ramp_enable) begin
      r_trig <= 1'b0;
      if (w_tick) begin
        r_presc <= '0;
        if (w_degen) begin
          // Collapsed range still triggers every tick so downstream timing runs.
          r_out   <= ramp_low;
          r_state <= UP;
          r_trig  <= 1'b1;
        end else begin
          case (r_state)
            UP: begin
              if (w_up >= w_high) begin
                r_out   <= ramp_high;
                r_state <= DOWN;
              end else begin
                r_out <= w_up[W_OUT-1:0];
              end
            end
            DOWN: begin
              if (w_dn <= w_low) begin
                r_out   <= ramp_low;
                r_state <= UP;
                r_trig  <= 1'b1;
              end else begin
                r_out <= w_dn[W_OUT-1:0];
              end
            end
            default: r_state <= UP;
          endcase
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end else begin
      r_trig <= 1'b0;
    end
  end

  assign ramp_out     = r_out;
  assign ramp_dir     = r_state;
  assign ramp_trigger = r_trig;

endmodule

// File: tb/tb_ramp_gen.sv
// Testbench for ramp_gen: directed sweeps from the test plan plus a random
// stream, all checked against a behavioural model of the sweep rules.
module tb_ramp_gen;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ramp_enable = 1'b0;
  logic               ramp_reset = 1'b0;
  logic signed [13:0] ramp_low = '0;
  logic signed [13:0] ramp_high = '0;
  logic        [12:0] step_size = '0;
  logic        [31:0] step_period = '0;
  logic signed [13:0] ramp_out;
  logic               ramp_dir;
  logic               ramp_trigger;

  int errors = 0;
  int checks = 0;

  // model state
  longint m_out = 0;
  longint m_dir = 0;
  longint m_presc = 0;
  longint m_trig = 0;
  longint cyc = 0;

  ramp_gen #(.W_OUT(14), .W_PER(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ramp_enable  (ramp_enable),
    .ramp_reset   (ramp_reset),
    .ramp_low     (ramp_low),
    .ramp_high    (ramp_high),
    .step_size    (step_size),
    .step_period  (step_period),
    .ramp_out     (ramp_out),
    .ramp_dir     (ramp_dir),
    .ramp_trigger (ramp_trigger)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_out = 0; m_dir = 0; m_presc = 0; m_trig = 0;
  endfunction

  // One clock edge of the sweep rules, using plain integer arithmetic.
  function automatic void model_edge();
    longint lo, hi, st, n;
    lo = longint'(ramp_low);
    hi = longint'(ramp_high);
    st = (step_size == 0) ? 1 : longint'(step_size);
    if (ramp_reset) begin
      m_out = lo; m_dir = 0; m_presc = 0; m_trig = 0;
    end else if (ramp_enable) begin
      m_trig = 0;
      if (m_presc == longint'(step_period)) begin
        m_presc = 0;
        if (lo >= hi) begin
          m_out = lo; m_dir = 0; m_trig = 1;
        end else if (m_dir == 0) begin
          n = m_out + st;
          if (n >= hi) begin m_out = hi; m_dir = 1; end
          else m_out = n;
        end else begin
          n = m_out - st;
          if (n <= lo) begin m_out = lo; m_dir = 0; m_trig = 1; end
          else m_out = n;
        end
      end else begin
        m_presc = (m_presc + 1) & 64'hFFFF_FFFF;
      end
    end else begin
      m_trig = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst) model_edge();
    #1;
    check("ramp_out", longint'(ramp_out), m_out);
    check("ramp_dir", longint'(ramp_dir), m_dir);
    check("ramp_trigger", longint'(ramp_trigger), m_trig);
  endtask

  task automatic setup(input int lo, input int hi, input int st, input int per);
    ramp_low = 14'(lo); ramp_high = 14'(hi);
    step_size = 13'(st); step_period = 32'(per);
    ramp_reset = 1'b1; ramp_enable = 1'b0;
    tick();
    ramp_reset = 1'b0; ramp_enable = 1'b1;
  endtask

  initial begin
    int exp1_out[9]  = '{-2, 0, 2, 4, 2, 0, -2, -4, -2};
    int exp1_dir[9]  = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    int exp1_trg[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    int exp2_out[7]  = '{2, 4, 5, 3, 1, 0, 2};
    int exp2_trg[7]  = '{0, 0, 0, 0, 0, 1, 0};
    int exp5_out[5]  = '{1, 2, 1, 0, 1};
    longint last_trig;
    int ntrig;
    bit found;

    #1;
    check("reset_out", longint'(ramp_out), 0);
    check("reset_dir", longint'(ramp_dir), 0);
    check("reset_trig", longint'(ramp_trigger), 0);
    #13 rst = 1'b0;
    model_reset();

    // 1: symmetric sweep, every clock
    setup(-4, 4, 2, 0);
    check("t1_load", longint'(ramp_out), -4);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("t1_out", longint'(ramp_out), exp1_out[i]);
      check("t1_dir", longint'(ramp_dir), exp1_dir[i]);
      check("t1_trig", longint'(ramp_trigger), exp1_trg[i]);
    end

    // 2: clamping at both turning points
    setup(0, 5, 2, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t2_out", longint'(ramp_out), exp2_out[i]);
      check("t2_trig", longint'(ramp_trigger), exp2_trg[i]);
    end

    // 3: prescaled sweep, trigger spacing and width
    setup(-4, 4, 2, 3);
    last_trig = -1; ntrig = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (ramp_trigger) begin
        if (last_trig >= 0) check("t3_period", cyc - last_trig, 32);
        last_trig = cyc; ntrig++;
        tick();
        check("t3_width", longint'(ramp_trigger), 0);
      end
    end
    check("t3_count", ntrig, 2);

    // 4: freeze on the falling leg at 2
    setup(-4, 4, 2, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (ramp_out == 2 && ramp_dir) found = 1;
    end
    check("t4_found", found, 1);
    ramp_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_hold", longint'(ramp_out), 2);
      check("t4_notrig", longint'(ramp_trigger), 0);
    end
    ramp_enable = 1'b1;
    tick(); check("t4_r0", longint'(ramp_out), 0);
    tick(); check("t4_r1", longint'(ramp_out), -2);
    tick(); check("t4_r2", longint'(ramp_out), -4);
    check("t4_trig", longint'(ramp_trigger), 1);

    // 5: degenerate range and zero step
    setup(3, 3, 1, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t5_deg_out", longint'(ramp_out), 3);
      check("t5_deg_trig", longint'(ramp_trigger), (i % 2 == 1) ? 1 : 0);
    end
    setup(0, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_step0", longint'(ramp_out), exp5_out[i]);
    end

    // 6: async reset mid-sweep, then reset+enable together
    setup(-100, 100, 7, 0);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("t6_async_out", longint'(ramp_out), 0);
    check("t6_async_dir", longint'(ramp_dir), 0);
    check("t6_async_trig", longint'(ramp_trigger), 0);
    model_reset();
    tick();
    #2 rst = 1'b0;
    ramp_low = -20; ramp_high = 20; ramp_reset = 1'b1; ramp_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_rr_out", longint'(ramp_out), -20);
      check("t6_rr_trig", longint'(ramp_trigger), 0);
    end
    ramp_reset = 1'b0;

    // random stream against the model
    for (int i = 0; i < 4000; i++) begin
      ramp_enable = ($urandom_range(0, 9) != 0);
      ramp_reset  = 1'b0;
      if ($urandom_range(0, 99) < 4) begin
        ramp_low  = 14'($signed($urandom_range(0, 80)) - 40);
        ramp_high = 14'($signed($urandom_range(0, 80)) - 40);
        step_size = 13'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 199) == 0) begin
        ramp_low = 14'sh2000; ramp_high = 14'sh1FFF;
        step_size = 13'($urandom_range(4000, 8191));
      end
      if ($urandom_range(0, 99) < 2) begin
        ramp_reset  = 1'b1;
        step_period = 32'($urandom_range(0, 3));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ramp_gen.md
Name: ramp_gen

Overview:
- Triangle sweep generator that sits directly upstream of the lock controller.
- Drives the scan ramp added to the actuator output while the loop is open.
- Emits ramp_trigger at the start of every sweep period; the lock controller uses this pulse to reset its time-trigger counter.
- Consumes ramp_enable back from the lock controller, which freezes the sweep the instant the lock engages.

Parameters:
- W_OUT, 14, width of signed ramp output and limits
- W_PER, 32, width of step-period prescaler

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ramp_enable  in  1  sweep runs while 1; output frozen while 0
- ramp_reset  in  1  synchronous level; restart sweep from ramp_low
- ramp_low  in  W_OUT  signed lower turning point
- ramp_high  in  W_OUT  signed upper turning point
- step_size  in  W_OUT-1  unsigned LSBs per update; 0 is treated as 1
- step_period  in  W_PER  unsigned; one update every step_period+1 clocks
- ramp_out  out  W_OUT  signed registered ramp value
- ramp_dir  out  1  0 = rising leg, 1 = falling leg
- ramp_trigger  out  1  one-clock pulse at the start of each period

Behaviour:
- Reset (rst): ramp_out=0, ramp_dir=0 (state UP), prescaler=0, ramp_trigger=0.
- Priority per edge: rst > ramp_reset > ramp_enable.
- ramp_reset high: ramp_out<=ramp_low, state UP, prescaler<=0, ramp_trigger<=0. No trigger is emitted on release.
- ramp_enable low (ramp_reset low): prescaler, state and ramp_out hold; ramp_trigger=0.
- Re-enable resumes with the same value, direction and prescaler count.
- Prescaler, while enabled:
  - tick = (prescaler==step_period).
  - On tick, prescaler<=0; otherwise prescaler+1.
  - step_period=0 gives a tick every clock.
- Update on a tick edge (all outputs registered, so one-clock latency from tick):
  - Arithmetic is done at W_OUT+1 bits signed, so there is no wrap.
  - UP: nxt=ramp_out+step. If nxt>=ramp_high: ramp_out<=ramp_high and state<=DOWN. Else ramp_out<=nxt.
  - DOWN: nxt=ramp_out-step. If nxt<=ramp_low: ramp_out<=ramp_low, state<=UP, ramp_trigger<=1. Else ramp_out<=nxt.
  - ramp_trigger is 0 on every other edge, so it is exactly one clock wide.
- Degenerate limits (ramp_low>=ramp_high): on each tick ramp_out<=ramp_low, state<=UP, ramp_trigger<=1. This gives a trigger every step_period+1 clocks and keeps the downstream counter usable.
- Limits changed mid-sweep:
  - ramp_out above ramp_high while UP: clamps to high on the next tick and turns.
  - ramp_out below ramp_low while DOWN: clamps to low on the next tick, turns, and triggers.
  - ramp_out outside the range in the other direction: walks back toward the range normally.
- Full period (non-degenerate) = 2 × ceil((high−low)/step) ticks.
- ramp_dir = state register (UP=0, DOWN=1).

Test Plan:
1. low=-4, high=4, step=2, period=0, pulse ramp_reset then enable.
   - Required: ramp_out -4,-2,0,2,4,2,0,-2,-4,-2…
   - ramp_dir goes 1 on the edge loading 4.
   - ramp_trigger high only on the cycle ramp_out becomes -4, repeating every 8 clocks.
2. low=0, high=5, step=2, period=0.
   - Required: 0,2,4,5,3,1,0,2… (clamps at 5 and 0); trigger only at each 0.
3. low=-4, high=4, step=2, period=3.
   - Required: ramp_out changes every 4th clock; trigger period 32 clocks; trigger still 1 clock wide.
4. Drop ramp_enable at ramp_out=2 during the falling leg for 10 clocks.
   - Required: ramp_out stays 2 and ramp_trigger stays 0 while disabled.
   - After re-enable: continues 0,-2,-4 with trigger at -4.
5. Degenerate and zero-step cases:
   - low=3, high=3, period=1: ramp_out=3, trigger every 2 clocks.
   - step=0, low=0, high=2: steps by 1 (0,1,2,1,0).
6. Reset cases:
   - Assert rst asynchronously mid-sweep: ramp_out=0, dir=0, trigger=0 immediately.
   - ramp_reset and ramp_enable both high: ramp_out=ramp_low held, no trigger.
